// File: rtl/uart_encoder.sv
// ---------------------------------------------------------------------------
// uart_encoder
//   Packs game events into short byte frames for a UART TX FIFO.
//   Each frame is one header byte (bit7 = 0) followed by 0..4 data bytes
//   (bit7 = 1). A receiver can always resync on the next byte with bit7 = 0.
//
//   Frames (header first):
//     CONNECT : 0x1A                                    (periodic heartbeat)
//     KEEPER  : 0x20, hi(pos), lo(pos)
//     SHOT    : 0x30, hi(x), lo(x), hi(y), lo(y)
//     SCORE   : {0,100,0,score_player}
//   where hi(v) = {11, v[11:6]} and lo(v) = {10, v[5:0]}.
//
//   Every source has its own pending flag; repeated requests coalesce.
//   Pending frames go out in the order SHOT > SCORE > KEEPER > CONNECT,
//   back to back, one byte per cycle whenever the FIFO is not full.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   link_enable   enables the heartbeat (CONNECT) generator
//   send_keeper   1-cycle request for a KEEPER frame
//   send_shot     1-cycle request for a SHOT frame
//   send_score    1-cycle request for a SCORE frame
//   keeper_pos    goalkeeper x position (12 bit)
//   shot_xpos     shot x position (12 bit)
//   shot_ypos     shot y position (12 bit)
//   score_player  local score (3 bit)
//   tx_full       UART TX FIFO full flag
//   w_data        byte presented to the FIFO (registered)
//   wr_uart       FIFO write strobe (combinational)
//   busy          high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_encoder #(
  parameter int HEARTBEAT_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_enable,
  input  logic        send_keeper,
  input  logic        send_shot,
  input  logic        send_score,
  input  logic [11:0] keeper_pos,
  input  logic [11:0] shot_xpos,
  input  logic [11:0] shot_ypos,
  input  logic [2:0]  score_player,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam int              HB_W    = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

  localparam logic [7:0] HDR_CONNECT = 8'h1A;
  localparam logic [7:0] HDR_KEEPER  = 8'h20;
  localparam logic [7:0] HDR_SHOT    = 8'h30;

  // Data byte carrying the upper / lower six bits of a 12-bit coordinate.
  function automatic logic [7:0] hi_byte(input logic [11:0] v);
    return {2'b11, v[11:6]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [11:0] v);
    return {2'b10, v[5:0]};
  endfunction

  // Control state
  logic [0:0]      r_state;
  logic [2:0]      r_idx;
  logic [7:0]      r_data;
  logic            r_pend_conn;
  logic            r_pend_keep;
  logic            r_pend_shot;
  logic            r_pend_score;
  logic [HB_W-1:0] r_hb_cnt;

  // Snapshot of the frame being sent
  logic [7:0]      r_bytes [5];
  logic [2:0]      r_len;

  // Combinational helpers
  logic            w_hb_wrap;
  logic            w_any_pend;
  logic            w_wr;
  logic            w_last;
  logic            w_launch;
  logic [2:0]      w_idx_next;
  logic            w_sel_conn;
  logic            w_sel_keep;
  logic            w_sel_shot;
  logic            w_sel_score;
  logic [7:0]      w_next_bytes [5];
  logic [2:0]      w_next_len;

  assign w_hb_wrap  = link_enable && (r_hb_cnt == HB_LAST);
  assign w_any_pend = r_pend_conn || r_pend_keep || r_pend_shot || r_pend_score;
  assign w_wr       = (r_state == SEND) && !tx_full;
  assign w_last     = (r_idx == (r_len - 3'd1));
  assign w_idx_next = r_idx + 3'd1;

  // A new frame starts either from IDLE or straight after the last byte of
  // the current one, so consecutive frames leave no idle cycle between them.
  assign w_launch   = w_any_pend && ((r_state == IDLE) || (w_wr && w_last));

  // Pick the highest-priority pending source and build its frame from the
  // live inputs; the result is only captured on a launch edge.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_sel_conn   = 1'b0;
    w_sel_keep   = 1'b0;
    w_sel_shot   = 1'b0;
    w_sel_score  = 1'b0;
    w_next_bytes = '{default: 8'h00};
    w_next_len   = 3'd1;
    if (r_pend_shot) begin
      w_sel_shot      = 1'b1;
      w_next_bytes[0] = HDR_SHOT;
      w_next_bytes[1] = hi_byte(shot_xpos);
      w_next_bytes[2] = lo_byte(shot_xpos);
      w_next_bytes[3] = hi_byte(shot_ypos);
      w_next_bytes[4] = lo_byte(shot_ypos);
      w_next_len      = 3'd5;
    end else if (r_pend_score) begin
      w_sel_score     = 1'b1;
      w_next_bytes[0] = {4'b0100, 1'b0, score_player};
    end else if (r_pend_keep) begin
      w_sel_keep      = 1'b1;
      w_next_bytes[0] = HDR_KEEPER;
      w_next_bytes[1] = hi_byte(keeper_pos);
      w_next_bytes[2] = lo_byte(keeper_pos);
      w_next_len      = 3'd3;
    end else begin
      w_sel_conn      = r_pend_conn;
      w_next_bytes[0] = HDR_CONNECT;
    end
  end

  // Frame sequencer, pending flags and heartbeat counter.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_data       <= 8'h00;
      r_pend_conn  <= 1'b0;
      r_pend_keep  <= 1'b0;
      r_pend_shot  <= 1'b0;
      r_pend_score <= 1'b0;
      r_hb_cnt     <= '0;
    end else begin
      if (w_launch) begin
        r_state <= SEND;
        r_idx   <= 3'd0;
        r_data  <= w_next_bytes[0];
      end else if (w_wr) begin
        if (w_last) begin
          r_state <= IDLE;
          r_idx   <= 3'd0;
        end else begin
          r_idx   <= w_idx_next;
          r_data  <= r_bytes[w_idx_next];
        end
      end

      // A request sampled on the very edge its flag is consumed re-arms the
      // flag, so exactly one further frame follows.
      r_pend_shot  <= (r_pend_shot  && !(w_launch && w_sel_shot))  || send_shot;
      r_pend_score <= (r_pend_score && !(w_launch && w_sel_score)) || send_score;
      r_pend_keep  <= (r_pend_keep  && !(w_launch && w_sel_keep))  || send_keeper;
      r_pend_conn  <= (r_pend_conn  && !(w_launch && w_sel_conn))  || w_hb_wrap;

      if (!link_enable || w_hb_wrap) begin
        r_hb_cnt <= '0;
      end else begin
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      end
    end
  end

  // NOTE: the frame snapshot is pure datapath and is left out of reset; it is
  // only read in SEND, which is always entered through a launch that loads it.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_bytes <= w_next_bytes;
      r_len   <= w_next_len;
    end
  end

  assign w_data  = r_data;
  assign wr_uart = w_wr;
  assign busy    = (r_state == SEND);

endmodule

// File: tb/tb_uart_encoder.sv
// ---------------------------------------------------------------------------
// tb_uart_encoder
//   Self-checking bench for uart_encoder (HEARTBEAT_CYCLES = 16).
//   Inputs change 1 ns after a rising edge; outputs are sampled on the
//   falling edge. A monitor records every FIFO write with its cycle number;
//   expected byte streams are built from the frame rules with arithmetic.
// ---------------------------------------------------------------------------
module tb_uart_encoder;

  logic        clk;
  logic        rst;
  logic        link_enable;
  logic        send_keeper;
  logic        send_shot;
  logic        send_score;
  logic [11:0] keeper_pos;
  logic [11:0] shot_xpos;
  logic [11:0] shot_ypos;
  logic [2:0]  score_player;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  logic [7:0] wr_q[$];
  int         wr_cyc_q[$];
  logic [7:0] exp_q[$];

  uart_encoder #(.HEARTBEAT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_enable  (link_enable),
    .send_keeper  (send_keeper),
    .send_shot    (send_shot),
    .send_score   (send_score),
    .keeper_pos   (keeper_pos),
    .shot_xpos    (shot_xpos),
    .shot_ypos    (shot_ypos),
    .score_player (score_player),
    .tx_full      (tx_full),
    .w_data       (w_data),
    .wr_uart      (wr_uart),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor plus strobe-rule watcher (wr_uart must be busy && !tx_full).
  always @(negedge clk) begin
    if (wr_uart === 1'b1) begin
      wr_q.push_back(w_data);
      wr_cyc_q.push_back(cyc);
    end
    if (rst === 1'b1 && wr_uart !== (busy & ~tx_full)) viol++;
  end

  // ---------------- reference model: frame contents ----------------------
  function automatic logic [7:0] hi6(input int v);
    return 8'(192 + (v / 64) % 64);
  endfunction

  function automatic logic [7:0] lo6(input int v);
    return 8'(128 + v % 64);
  endfunction

  task automatic exp_shot(input int x, input int y);
    exp_q.push_back(8'h30);
    exp_q.push_back(hi6(x)); exp_q.push_back(lo6(x));
    exp_q.push_back(hi6(y)); exp_q.push_back(lo6(y));
  endtask

  task automatic exp_keeper(input int p);
    exp_q.push_back(8'h20);
    exp_q.push_back(hi6(p)); exp_q.push_back(lo6(p));
  endtask

  task automatic exp_score(input int s);
    exp_q.push_back(8'(64 + s));
  endtask

  task automatic clear_queues();
    wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
  endtask

  // Drives tx_full (optionally random) until busy stays low for 3 samples.
  task automatic run_until_idle(input bit stall, output bit ok);
    int idle_run;
    idle_run = 0;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      tx_full = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      if (busy) idle_run = 0; else idle_run++;
      if (idle_run >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    tx_full = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (wr_uart !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr_uart); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (w_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", w_data); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || wr_q.size() != 0) begin bad++; $display("FAIL post_reset_idle busy=%b writes=%0d exp busy=0 writes=0", busy, wr_q.size()); end
  endtask

  task automatic test_score();
    clear_queues();
    @(posedge clk); #1;
    score_player = 3'd3; send_score = 1'b1;
    @(posedge clk); #1 send_score = 1'b0;         // edge k sampled the pulse
    @(negedge clk);                               // cycle after edge k
    total++; if (wr_uart !== 1'b0) begin bad++; $display("FAIL score_early got=%b exp=0", wr_uart); end
    @(negedge clk);                               // cycle after edge k+1
    total++; if (wr_uart !== 1'b1 || w_data !== 8'h43) begin bad++; $display("FAIL score_hdr got wr=%b data=%h exp wr=1 data=43", wr_uart, w_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL score_busy got=%b exp=1", busy); end
    @(negedge clk);
    total++; if (wr_uart !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL score_end got wr=%b busy=%b exp 0 0", wr_uart, busy); end
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL score_count got=%0d exp=1", wr_q.size()); end
  endtask

  task automatic test_shot_stall();
    bit ok;
    clear_queues();
    exp_shot(12'h3FF, 12'h1C0);
    @(posedge clk); #1;
    shot_xpos = 12'h3FF; shot_ypos = 12'h1C0; send_shot = 1'b1;
    @(posedge clk); #1 send_shot = 1'b0;          // edge k
    repeat (3) @(posedge clk); #1 tx_full = 1'b1; // bytes 1 and 2 written, byte 3 loaded
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (wr_uart !== 1'b0 || w_data !== 8'hBF || busy !== 1'b1) begin
        bad++; $display("FAIL stall_%0d got wr=%b data=%h busy=%b exp wr=0 data=bf busy=1", i, wr_uart, w_data, busy);
      end
    end
    @(posedge clk); #1 tx_full = 1'b0;
    run_until_idle(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL shot_stall_timeout got=busy exp=idle"); end
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL shot_stall_len got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL shot_stall_byte%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_priority();
    bit ok;
    int gaps;
    logic [11:0] x, y;
    logic [2:0]  s;
    clear_queues();
    x = 12'($urandom); y = 12'($urandom); s = 3'($urandom);
    exp_shot(x, y); exp_score(s); exp_keeper(12'h040);
    @(posedge clk); #1;
    shot_xpos = x; shot_ypos = y; score_player = s; keeper_pos = 12'h040;
    send_shot = 1'b1; send_score = 1'b1; send_keeper = 1'b1;
    @(posedge clk); #1;
    send_shot = 1'b0; send_score = 1'b0; send_keeper = 1'b0;
    run_until_idle(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_timeout got=busy exp=idle"); end
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL prio_len got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL prio_byte%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
    end
    gaps = 0;
    for (int i = 1; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] != wr_cyc_q[i-1] + 1) gaps++;
    total++; if (gaps != 0) begin bad++; $display("FAIL prio_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_coalesce();
    bit ok;
    int gaps;
    logic [11:0] xa, xc, y;
    clear_queues();
    xa = 12'($urandom); y = 12'($urandom); xc = xa ^ 12'hA5C;
    exp_shot(xa, y); exp_shot(xc, y);
    @(posedge clk); #1;
    shot_xpos = xa; shot_ypos = y; send_shot = 1'b1;
    @(posedge clk); #1 send_shot = 1'b0;                     // edge k
    @(posedge clk); #1 shot_xpos = xc; send_shot = 1'b1;     // after launch edge k+1
    @(posedge clk); #1 send_shot = 1'b0;
    @(posedge clk); #1 send_shot = 1'b1;
    @(posedge clk); #1 send_shot = 1'b0;
    run_until_idle(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL coal_timeout got=busy exp=idle"); end
    total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL coal_len got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL coal_byte%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
    end
    gaps = 0;
    for (int i = 1; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] != wr_cyc_q[i-1] + 1) gaps++;
    total++; if (gaps != 0) begin bad++; $display("FAIL coal_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_heartbeat();
    int en_cyc;
    clear_queues();
    @(posedge clk); #1 link_enable = 1'b1;
    en_cyc = cyc;
    // Edges en_cyc+1 .. en_cyc+55 see link_enable high: wraps on the 16th,
    // 32nd and 48th of them, each header written one edge later.
    repeat (55) @(posedge clk); #1 link_enable = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    total++; if (wr_q.size() != 3) begin bad++; $display("FAIL hb_count got=%0d exp=3", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      total++; if (wr_cyc_q[0] - en_cyc != 17) begin bad++; $display("FAIL hb_first got=%0d exp=17", wr_cyc_q[0] - en_cyc); end
    end
    for (int i = 0; i < wr_q.size(); i++) begin
      total++; if (wr_q[i] !== 8'h1A) begin bad++; $display("FAIL hb_byte%0d got=%h exp=1a", i, wr_q[i]); end
      if (i > 0) begin
        total++; if (wr_cyc_q[i] - wr_cyc_q[i-1] != 16) begin bad++; $display("FAIL hb_period%0d got=%0d exp=16", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] x;
    clear_queues();
    x = 12'($urandom);
    @(posedge clk); #1;
    shot_xpos = x; shot_ypos = 12'($urandom); send_shot = 1'b1;
    @(posedge clk); #1 send_shot = 1'b0;          // edge k
    repeat (4) @(negedge clk);                    // cycle carrying byte 3
    total++; if (wr_uart !== 1'b1 || w_data !== lo6(x)) begin bad++; $display("FAIL rst_mid_byte3 got wr=%b data=%h exp wr=1 data=%h", wr_uart, w_data, lo6(x)); end
    #1 rst = 1'b0;
    #1;
    total++; if (wr_uart !== 1'b0 || w_data !== 8'h00 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_abort got wr=%b data=%h busy=%b exp 0 00 0", wr_uart, w_data, busy);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    wr_q.delete(); wr_cyc_q.delete();
    repeat (20) @(negedge clk);
    total++; if (wr_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_resume got writes=%0d busy=%b exp 0 0", wr_q.size(), busy); end
  endtask

  task automatic test_random();
    bit ok;
    int mask;
    logic [11:0] x, y, p;
    logic [2:0]  s;
    for (int it = 0; it < 30; it++) begin
      clear_queues();
      mask = $urandom_range(1, 7);
      x = 12'($urandom); y = 12'($urandom); p = 12'($urandom); s = 3'($urandom);
      if (mask[0]) exp_shot(x, y);
      if (mask[1]) exp_score(s);
      if (mask[2]) exp_keeper(p);
      @(posedge clk); #1;
      shot_xpos = x; shot_ypos = y; keeper_pos = p; score_player = s;
      send_shot = mask[0]; send_score = mask[1]; send_keeper = mask[2];
      @(posedge clk); #1;
      send_shot = 1'b0; send_score = 1'b0; send_keeper = 1'b0;
      run_until_idle(1'b1, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=busy exp=idle", it); end
      total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, wr_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (viol != 0) begin bad++; $display("FAIL strobe_rule got=%0d violations exp=0", viol); end
  endtask

  initial begin
    rst = 1'b0; link_enable = 1'b0; tx_full = 1'b0;
    send_keeper = 1'b0; send_shot = 1'b0; send_score = 1'b0;
    keeper_pos = '0; shot_xpos = '0; shot_ypos = '0; score_player = '0;
    test_reset();
    test_score();
    test_shot_stall();
    test_priority();
    test_coalesce();
    test_heartbeat();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
